// File: rtl/hazard_scoreboard_pkg.sv
// Shared sizing and types for the register hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 2 ** ADDR_W;
  localparam int LAT_W  = 2;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [LAT_W-1:0]  lat_t;

  localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One register's in-flight state: busy flag plus result-ready countdown.
module scoreboard_entry
  import hazard_scoreboard_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             set,
  input  logic             clear,
  input  logic [LAT_W-1:0] lat,
  output logic             busy,
  output logic [LAT_W-1:0] cnt
);

  // A set in the same cycle as a clear wins, so a new producer is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (set) begin
      busy <= 1'b1;
      cnt  <= lat;
    end else if (clear) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - lat_t'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue/writeback hazard scoreboard: stall and bypass selection for 16 registers.
// Build option: define ZERO_REG_EN to hardwire register 0 to zero.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic              issue_rs1_use,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic              issue_rs2_use,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_wr_en,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  output logic              stall,
  output logic              fwd_need_a,
  output logic              fwd_need_b,
  output logic [NREGS-1:0]  busy_vec,
  output logic [ADDR_W:0]   busy_count
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] ebusy;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  lat_t             cnt [NREGS];
  logic             init_done;
  logic             raw_a, raw_b, waw;
  logic             accept, set_en, inc, dec;

  // A writeback landing this cycle hides the register's hazard combinationally.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      ebusy[r]   = busy[r] & ~(wb_valid && (wb_rd == reg_addr_t'(r)));
      clr_vec[r] = wb_valid && (wb_rd == reg_addr_t'(r));
    end
`ifdef ZERO_REG_EN
    ebusy[ZERO_REG] = 1'b0;
`endif
  end

  always_comb begin
    raw_a      = issue_rs1_use & ebusy[issue_rs1] & (cnt[issue_rs1] != '0);
    raw_b      = issue_rs2_use & ebusy[issue_rs2] & (cnt[issue_rs2] != '0);
    waw        = issue_wr_en & ebusy[issue_rd];
    stall      = issue_valid & (~init_done | raw_a | raw_b | waw);
    fwd_need_a = issue_valid & init_done & issue_rs1_use & ebusy[issue_rs1] &
                 (cnt[issue_rs1] == '0);
    fwd_need_b = issue_valid & init_done & issue_rs2_use & ebusy[issue_rs2] &
                 (cnt[issue_rs2] == '0);
    accept     = issue_valid & ~stall;
`ifdef ZERO_REG_EN
    set_en     = accept & issue_wr_en & (issue_rd != ZERO_REG);
`else
    set_en     = accept & issue_wr_en;
`endif
    for (int unsigned r = 0; r < NREGS; r++) begin
      set_vec[r] = set_en && (issue_rd == reg_addr_t'(r));
    end
    // Re-setting a register that retires this same cycle leaves the count unchanged.
    inc = set_en & ~busy[issue_rd];
    dec = wb_valid & busy[wb_rd] & ~(set_en && (issue_rd == wb_rd));
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_entry
    scoreboard_entry u_entry (
      .clock (clock),
      .reset (reset),
      .set   (set_vec[g]),
      .clear (clr_vec[g]),
      .lat   (issue_lat),
      .busy  (busy[g]),
      .cnt   (cnt[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      init_done  <= 1'b0;
      busy_count <= '0;
    end else begin
      init_done <= 1'b1;
      if (inc && !dec) begin
        busy_count <= busy_count + (ADDR_W+1)'(1);
      end else if (dec && !inc) begin
        busy_count <= busy_count - (ADDR_W+1)'(1);
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: a cycle-level reference model predicts outputs, a monitor compares.
module tb_hazard_scoreboard;
  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic        issue_rs1_use, issue_rs2_use, issue_wr_en, wb_valid;
  logic [1:0]  issue_lat;
  logic        stall, fwd_need_a, fwd_need_b;
  logic [15:0] busy_vec;
  logic [4:0]  busy_count;

  typedef struct {
    logic        stall;
    logic        fa;
    logic        fb;
    logic [15:0] bv;
    logic [4:0]  bc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: a register is busy from accepted issue until writeback,
  // and its result is forwardable once the cycle count reaches ready_at.
  bit   m_busy [16];
  int   m_ready_at [16];
  bit   m_init;
  int   now;

  hazard_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs1_use (issue_rs1_use),
    .issue_rs2     (issue_rs2),
    .issue_rs2_use (issue_rs2_use),
    .issue_rd      (issue_rd),
    .issue_wr_en   (issue_wr_en),
    .issue_lat     (issue_lat),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .stall         (stall),
    .fwd_need_a    (fwd_need_a),
    .fwd_need_b    (fwd_need_b),
    .busy_vec      (busy_vec),
    .busy_count    (busy_count)
  );

  always #5 clock = ~clock;

  function automatic bit hardwired(int r);
`ifdef ZERO_REG_EN
    return r == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit in_flight(int r);
    return m_busy[r] && !(wb_valid && int'(wb_rd) == r) && !hardwired(r);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", {15'd0, stall}, {15'd0, e.stall});
      chk("fwd_need_a", {15'd0, fwd_need_a}, {15'd0, e.fa});
      chk("fwd_need_b", {15'd0, fwd_need_b}, {15'd0, e.fb});
      chk("busy_vec", busy_vec, e.bv);
      chk("busy_count", {11'd0, busy_count}, {11'd0, e.bc});
    end
  end

  task automatic step(input bit rst, input bit iv,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit wr, input int lat,
                      input bit wv, input int wrd);
    exp_t e;
    bit   acc;
    int   n;
    reset = rst; issue_valid = iv;
    issue_rs1 = 4'(rs1); issue_rs1_use = u1;
    issue_rs2 = 4'(rs2); issue_rs2_use = u2;
    issue_rd = 4'(rd); issue_wr_en = wr; issue_lat = 2'(lat);
    wb_valid = wv; wb_rd = 4'(wrd);
    e.stall = iv && (!m_init
              || (u1 && in_flight(rs1) && now < m_ready_at[rs1])
              || (u2 && in_flight(rs2) && now < m_ready_at[rs2])
              || (wr && in_flight(rd)));
    e.fa = iv && m_init && u1 && in_flight(rs1) && now >= m_ready_at[rs1];
    e.fb = iv && m_init && u2 && in_flight(rs2) && now >= m_ready_at[rs2];
    n = 0;
    for (int r = 0; r < 16; r++) begin
      e.bv[r] = m_busy[r];
      n += int'(m_busy[r]);
    end
    e.bc = 5'(n);
    q.push_back(e);
    acc = iv && !e.stall;
    @(posedge clock);
    if (rst) begin
      m_init = 1'b0;
      for (int r = 0; r < 16; r++) begin
        m_busy[r] = 1'b0;
        m_ready_at[r] = 0;
      end
    end else begin
      m_init = 1'b1;
      if (wv) m_busy[wrd] = 1'b0;
      if (acc && wr && !hardwired(rd)) begin
        m_busy[rd] = 1'b1;
        m_ready_at[rd] = now + 1 + lat;
      end
    end
    now++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    now = 0;
    m_init = 1'b0;
    for (int r = 0; r < 16; r++) begin
      m_busy[r] = 1'b0;
      m_ready_at[r] = 0;
    end
    @(posedge clock); #1;
    // reset held, then an issue that must stall while init completes
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    // RAW with latency 2, then bypass until writeback
    step(0, 1, 0, 0, 0, 0, 5, 1, 2, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 1, 5);
    step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    // ALU result forwardable next cycle via rs2
    step(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    step(0, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    // WAW stall, then same issue with a coincident writeback (set wins)
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 7, 1, 1, 1, 7);
    idle(2);
    // writeback to an idle register
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    idle(1);
    // register 0 as destination with latency 3
    step(0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    // reset mid-operation, with a stale writeback after it
    step(0, 1, 0, 0, 0, 0, 11, 1, 3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11);
    idle(1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 1),
           $urandom_range(0, 15), $urandom_range(0, 2) != 0,
           $urandom_range(0, 3),
           $urandom_range(0, 9) < 4, $urandom_range(0, 15));
    end
    idle(1);
    @(negedge clock); #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
